hdmi_sysid_checker: RTL and testbench

Avalon-MM read initiator that interrogates the HDMI system's sysid slave at bring-up. On a start pulse it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and reports pass/fail to the host-side status logic. It sits between the boot/status sequencer and the sysid control slave in the HDMI Qsys fabric.

---
 rtl/hdmi_sysid_pkg.sv | 18 +
 rtl/hdmi_sysid_checker.sv | 151 +++++++++++++++
 tb/tb_hdmi_sysid_checker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_sysid_pkg.sv
// Shared definitions for the HDMI sysid bring-up checker: FSM state encoding,
// sysid slave word addresses and the default build timestamp.
package hdmi_sysid_pkg;

  typedef logic [1:0] sysid_state_t;

  localparam sysid_state_t StIdle   = 2'd0;
  localparam sysid_state_t StRdId   = 2'd1;
  localparam sysid_state_t StRdTs   = 2'd2;
  localparam sysid_state_t StFinish = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Timestamp of the reference Qsys build (decimal 1539181415).
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5BBE_0B67;

endpackage

// File: rtl/hdmi_sysid_checker.sv
// Avalon-MM read initiator that fetches the sysid ID and timestamp words on a
// start pulse and reports whether both match the expected build values.
// Optional stall timeout enabled by defining SYSID_CHECK_TIMEOUT_EN.
module hdmi_sysid_checker
  import hdmi_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);

  sysid_state_t state_q, state_d;
  logic         read_q, read_d;
  logic         addr_q, addr_d;
  logic         pass_q, pass_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  id_q, id_d;
  logic [31:0]  ts_q, ts_d;
  logic         stall_abort;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_read;

  assign in_read     = (state_q == StRdId) || (state_q == StRdTs);
  // Abort on the stall cycle that brings the stall count up to TIMEOUT_CYCLES.
  assign stall_abort = in_read && avm_waitrequest && (cnt_q == CntLast);

  // Stall counter: restart whenever the state changes, count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_read && avm_waitrequest) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign stall_abort        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic; bus strobes are registered so they hold through stalls.
  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    id_d      = id_q;
    ts_d      = ts_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRdId;
          read_d    = 1'b1;
          addr_d    = SYSID_ADDR_ID;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StRdId, StRdTs: begin
        if (stall_abort) begin
          state_d   = StFinish;
          read_d    = 1'b0;
          addr_d    = SYSID_ADDR_ID;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else if (!avm_waitrequest) begin
          if (state_q == StRdId) begin
            id_d    = avm_readdata;
            state_d = StRdTs;
            addr_d  = SYSID_ADDR_TS;
          end else begin
            ts_d    = avm_readdata;
            state_d = StFinish;
            read_d  = 1'b0;
            addr_d  = SYSID_ADDR_ID;
            // ts_value is captured on this same edge, so compare the bus word.
            pass_d  = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      read_q    <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFinish);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_hdmi_sysid_checker.sv
// Scoreboard bench for hdmi_sysid_checker: stimulus pushes the expected result
// of each check, a monitor pops and compares it whenever done pulses.
module tb_hdmi_sysid_checker;

  localparam logic [31:0] GoodTs = 32'h5BBE_0B67;
  localparam int unsigned ToCycles = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, timeout;
  logic [31:0] id_value, ts_value;

  hdmi_sysid_checker #(
    .EXPECTED_ID    (32'h0000_0000),
    .EXPECTED_TS    (GoodTs),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .timeout         (timeout)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave model: word select drives data, per-word stall counts drive waitrequest.
  logic [31:0] id_word, ts_word;
  int          id_stall, ts_stall, stall_cnt;
  logic        stuck;

  assign avm_readdata    = avm_address ? ts_word : id_word;
  assign avm_waitrequest = avm_read &&
                           (stuck || (stall_cnt < (avm_address ? ts_stall : id_stall)));

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt <= 0;
    else if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    logic        pass;
    logic        to;
    logic [31:0] id;
    logic [31:0] ts;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  logic [31:0] hold_id = '0;
  logic [31:0] hold_ts = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass", {31'd0, pass}, {31'd0, e.pass});
        check("timeout", {31'd0, timeout}, {31'd0, e.to});
        check("id_value", id_value, e.id);
        check("ts_value", ts_value, e.ts);
      end
    end
  end

  // Drive a start pulse at cycle N; returns at cycle N+1 with start low.
  task automatic issue(input logic [31:0] id_w, input logic [31:0] ts_w,
                       input int id_st, input int ts_st, input bit push);
    exp_t e;
    id_word  = id_w;
    ts_word  = ts_w;
    id_stall = id_st;
    ts_stall = ts_st;
    if (push) begin
      e.pass  = (id_w == 32'h0) && (ts_w == GoodTs);
      e.to    = 1'b0;
      e.id    = id_w;
      e.ts    = ts_w;
      e.cyc   = cyc + 3 + id_st + ts_st;
      hold_id = id_w;
      hold_ts = ts_w;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: got no done within %0d cycles expected done pulse", budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    check({tag, "_avm_address"}, {31'd0, avm_address}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_id_value"}, id_value, 32'd0);
    check({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    int n_before;
    reset_n  = 1'b0;
    start    = 1'b0;
    stuck    = 1'b0;
    id_word  = '0;
    ts_word  = GoodTs;
    id_stall = 0;
    ts_stall = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst");

    // Matching words, no stalls; check bus sequencing along the way.
    issue(32'h0, GoodTs, 0, 0, 1'b1);
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_read", {31'd0, avm_read}, 32'd1);
    check("c1_addr", {31'd0, avm_address}, 32'd0);
    @(negedge clock);
    check("c2_read", {31'd0, avm_read}, 32'd1);
    check("c2_addr", {31'd0, avm_address}, 32'd1);
    wait_idle(20);
    check("c_idle_busy", {31'd0, busy}, 32'd0);
    check("c_idle_read", {31'd0, avm_read}, 32'd0);
    check("pass_held", {31'd0, pass}, 32'd1);

    // Timestamp off by one.
    issue(32'h0, 32'h5BBE_0B68, 0, 0, 1'b1);
    wait_idle(20);
    check("fail_held", {31'd0, pass}, 32'd0);

    // Wrong ID with a stalled timestamp read.
    issue(32'h0000_0001, GoodTs, 0, 2, 1'b1);
    wait_idle(20);

    // Five stall cycles on word 0: strobe and address must hold.
    issue(32'h0, GoodTs, 5, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("stall_read", {31'd0, avm_read}, 32'd1);
      check("stall_addr", {31'd0, avm_address}, 32'd0);
      @(negedge clock);
    end
    check("post_stall_addr", {31'd0, avm_address}, 32'd1);
    wait_idle(20);

    // Second start on the following cycle must be dropped.
    n_before = n_done;
    exp_q.push_back('{pass: 1'b1, to: 1'b0, id: 32'h0, ts: GoodTs, cyc: cyc + 3});
    id_word = '0; ts_word = GoodTs; id_stall = 0; ts_stall = 0;
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    wait_idle(20);
    repeat (5) @(negedge clock);
    check("single_done", n_done - n_before, 32'd1);

    // Reset asserted while in RD_TS: no completion, everything back to reset.
    n_before = n_done;
    issue(32'h0, GoodTs, 0, 0, 1'b0);
    @(negedge clock);
    check("rdts_addr", {31'd0, avm_address}, 32'd1);
    #2 reset_n = 1'b0;
    hold_id = '0;
    hold_ts = '0;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("no_done_after_rst", n_done - n_before, 32'd0);

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Waitrequest stuck: abort after ToCycles stall cycles.
    stuck = 1'b1;
    exp_q.push_back('{pass: 1'b0, to: 1'b1, id: hold_id, ts: hold_ts,
                      cyc: cyc + 1 + ToCycles});
    issue(32'h0, GoodTs, 0, 0, 1'b0);
    repeat (ToCycles - 1) @(negedge clock);
    check("to_read_last_stall", {31'd0, avm_read}, 32'd1);
    @(negedge clock);
    check("to_read_dropped", {31'd0, avm_read}, 32'd0);
    wait_idle(40);
    stuck = 1'b0;
`endif

    // A clean check afterwards passes and clears any timeout flag.
    issue(32'h0, GoodTs, 1, 1, 1'b1);
    wait_idle(20);
    check("final_timeout_clear", {31'd0, timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
